vector_lane_splitter: RTL and testbench

//  Distribution end of the 4-lane vector datapath; the coalesce stage is the collection end.
//  - Accepts one decoded operation from fetch-regs: two 256-bit vector operands, an element count and an opcode tag.
//  - Issues it to the four exec_to_wb_pipe lanes as ceil(len/4) beats of four 16-bit elements.
//  - Holds upstream stalled (in_ready low) while beats remain.
//  - Scalar ops pass as a single beat on lane 0.

---
 rtl/vec_pkg.sv | 36 +++
 rtl/lane_mask_gen.sv | 36 +++
 rtl/vector_lane_splitter.sv | 169 ++++++++++++++++
 tb/tb_vector_lane_splitter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// vec_pkg: shared constants and types for the 4-lane vector datapath.
//   Geometry (LANES, ELEM_W, VLEN, VEC_W), splitter FSM state encoding,
//   opcode tags shared with decode, and the element-count clamp helper.
package vec_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned ELEM_W = 16;
    localparam int unsigned VLEN   = 16;
    localparam int unsigned VEC_W  = VLEN * ELEM_W;   // 256
    localparam int unsigned LANE_W = LANES * ELEM_W;  // 64
    localparam int unsigned LEN_W  = 5;
    localparam int unsigned BEAT_W = 2;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned IDX_W  = 4;

    typedef enum logic {
        StIdle  = 1'b0,
        StIssue = 1'b1
    } state_e;

    // Opcode tags, passed through unchanged by the splitter.
    localparam logic [TAG_W-1:0] OpVAdd = 4'h0;
    localparam logic [TAG_W-1:0] OpVSub = 4'h1;
    localparam logic [TAG_W-1:0] OpVMul = 4'h2;
    localparam logic [TAG_W-1:0] OpVMac = 4'h3;
    localparam logic [TAG_W-1:0] OpVAnd = 4'h4;
    localparam logic [TAG_W-1:0] OpVOr  = 4'h5;
    localparam logic [TAG_W-1:0] OpVXor = 4'h6;
    localparam logic [TAG_W-1:0] OpVMov = 4'h7;

    // Element counts above VLEN saturate to a full register.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(VLEN)) ? LEN_W'(VLEN) : len;
    endfunction

endpackage

// File: rtl/lane_mask_gen.sv
// lane_mask_gen: combinational lane-valid mask and last-beat flag for one beat.
//   beat       in  2  beat number within the operation
//   len_eff    in  5  clamped element count, 0..16
//   scalar     in  1  scalar op: single beat, lane 0 only
//   lane_valid out 4  bit k set when lane k carries a real element
//   last       out 1  this beat is the final one of the operation
module lane_mask_gen
    import vec_pkg::*;
(
    input  logic [BEAT_W-1:0] beat,
    input  logic [LEN_W-1:0]  len_eff,
    input  logic              scalar,
    output logic [LANES-1:0]  lane_valid,
    output logic              last
);

    logic [2:0] nbeats;

    always_comb begin
        lane_valid = '0;
        nbeats     = 3'd1;
        if (scalar) begin
            lane_valid[0] = 1'b1;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                lane_valid[k] = (LEN_W'({1'b0, beat, 2'b00}) + LEN_W'(k)) < len_eff;
            end
            // len 0 still issues one empty beat so the op retires.
            if (len_eff != '0) begin
                nbeats = 3'((len_eff + LEN_W'(3)) >> 2);
            end
        end
        last = ({1'b0, beat} == (nbeats - 3'd1));
    end

endmodule

// File: rtl/vector_lane_splitter.sv
// vector_lane_splitter: issues one vector op to the four exec lanes as
// ceil(len/4) beats of four 16-bit elements; scalar ops go as one beat on lane 0.
// Optional build macro: VSPLIT_BYPASS_EN (beat 0 presented combinationally from
// the input when idle; default build registers everything, latency 1).
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  upstream handshake; in_ready low while beats remain
//   in_scalar       scalar op flag
//   in_tag          opcode tag, copied to every beat
//   in_len          element count 0..31, clamped to 16
//   in_vec_a/x      256-bit operands, element i at [16i+15:16i]
//   out_valid/ready lane handshake (out_ready = AND of lane readies)
//   out_a/x         lane k element at [16k+15:16k], zero on invalid lanes
//   out_lane_valid  per-lane real-element mask
//   out_base_idx    element index on lane 0 (beat*4)
//   out_last        final beat of the op
//   out_tag         captured opcode tag
module vector_lane_splitter
    import vec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_scalar,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [LEN_W-1:0]  in_len,
    input  logic [VEC_W-1:0]  in_vec_a,
    input  logic [VEC_W-1:0]  in_vec_x,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_a,
    output logic [LANE_W-1:0] out_x,
    output logic [LANES-1:0]  out_lane_valid,
    output logic [IDX_W-1:0]  out_base_idx,
    output logic              out_last,
    output logic [TAG_W-1:0]  out_tag
);

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [LEN_W-1:0]    len_q;
    logic                scalar_q;
    logic [TAG_W-1:0]    tag_q;
    logic [VEC_W-1:0]    a_q, x_q;

    logic                use_in;
    logic                bypass;
    logic [BEAT_W-1:0]   cur_beat;
    logic [LEN_W-1:0]    cur_len;
    logic                cur_scalar;
    logic [TAG_W-1:0]    cur_tag;
    logic [VEC_W-1:0]    cur_a, cur_x;
    logic [LANES-1:0]    mask;
    logic                mask_last;
    logic                hs;
    logic                accept;
    logic [IDX_W-1:0]    idx;

`ifdef VSPLIT_BYPASS_EN
    // When idle, the beat logic looks straight at the input op.
    assign use_in = (state_q == StIdle);
    assign bypass = use_in && in_valid;
`else
    assign use_in = 1'b0;
    assign bypass = 1'b0;
`endif

    assign cur_beat   = use_in ? '0 : beat_q;
    assign cur_len    = use_in ? clamp_len(in_len) : len_q;
    assign cur_scalar = use_in ? in_scalar : scalar_q;
    assign cur_tag    = use_in ? in_tag : tag_q;
    assign cur_a      = use_in ? in_vec_a : a_q;
    assign cur_x      = use_in ? in_vec_x : x_q;

    lane_mask_gen u_mask (
        .beat       (cur_beat),
        .len_eff    (cur_len),
        .scalar     (cur_scalar),
        .lane_valid (mask),
        .last       (mask_last)
    );

    assign out_valid = (state_q == StIssue) || bypass;
    assign hs        = out_valid && out_ready;
    assign accept    = in_valid && in_ready;

    // Lane data; anything not carrying a real element reads as zero.
    always_comb begin
        out_a = '0;
        out_x = '0;
        idx   = '0;
        for (int k = 0; k < LANES; k++) begin
            idx = {cur_beat, 2'(k)};
            if (out_valid && mask[k]) begin
                out_a[k*ELEM_W +: ELEM_W] = cur_a[int'(idx)*ELEM_W +: ELEM_W];
                out_x[k*ELEM_W +: ELEM_W] = cur_x[int'(idx)*ELEM_W +: ELEM_W];
            end
        end
    end

    assign out_lane_valid = out_valid ? mask : '0;
    assign out_last       = out_valid && mask_last;
    assign out_base_idx   = out_valid ? {cur_beat, 2'b00} : '0;
    assign out_tag        = out_valid ? cur_tag : '0;

    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
`ifdef VSPLIT_BYPASS_EN
            // A multi-beat op is taken even if beat 0 stalls; it is held in ISSUE.
            StIdle:  in_ready = out_ready || !mask_last;
`else
            StIdle:  in_ready = 1'b1;
`endif
            StIssue: in_ready = out_ready && mask_last;
            default: in_ready = 1'b0;
        endcase
        in_ready = in_ready && !rst;
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        if ((state_q == StIssue) && hs) begin
            if (mask_last) begin
                state_d = StIdle;
            end else begin
                beat_d = beat_q + 2'd1;
            end
        end
        if (accept) begin
            state_d = StIssue;
            beat_d  = '0;
`ifdef VSPLIT_BYPASS_EN
            if ((state_q == StIdle) && out_ready) begin
                // Beat 0 already went out this cycle.
                if (mask_last) begin
                    state_d = StIdle;
                end else begin
                    beat_d = 2'd1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            beat_q   <= '0;
            len_q    <= '0;
            scalar_q <= 1'b0;
            tag_q    <= '0;
            a_q      <= '0;
            x_q      <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (accept) begin
                len_q    <= clamp_len(in_len);
                scalar_q <= in_scalar;
                tag_q    <= in_tag;
                a_q      <= in_vec_a;
                x_q      <= in_vec_x;
            end
        end
    end

endmodule

// File: tb/tb_vector_lane_splitter.sv
module tb_vector_lane_splitter;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_scalar;
    logic [3:0]   in_tag;
    logic [4:0]   in_len;
    logic [255:0] in_vec_a;
    logic [255:0] in_vec_x;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_a;
    logic [63:0]  out_x;
    logic [3:0]   out_lane_valid;
    logic [3:0]   out_base_idx;
    logic         out_last;
    logic [3:0]   out_tag;

    vector_lane_splitter dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_scalar      (in_scalar),
        .in_tag         (in_tag),
        .in_len         (in_len),
        .in_vec_a       (in_vec_a),
        .in_vec_x       (in_vec_x),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_a          (out_a),
        .out_x          (out_x),
        .out_lane_valid (out_lane_valid),
        .out_base_idx   (out_base_idx),
        .out_last       (out_last),
        .out_tag        (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] x;
        logic [3:0]  lv;
        logic [3:0]  base;
        logic        last;
        logic [3:0]  tag;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    // Staged next op, driven onto the inputs inside cyc().
    logic         nxt_sc;
    logic [3:0]   nxt_tag;
    logic [4:0]   nxt_len;
    logic [255:0] nxt_a;
    logic [255:0] nxt_x;

    // Values seen at the last sample point, for directed spot checks.
    beat_t obs_s;
    logic  inr_s;

    function automatic beat_t dut_beat();
        beat_t b;
        b.a    = out_a;
        b.x    = out_x;
        b.lv   = out_lane_valid;
        b.base = out_base_idx;
        b.last = out_last;
        b.tag  = out_tag;
        return b;
    endfunction

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: the beats an op should produce, from the element-count rules.
    task automatic push_op(input logic sc, input logic [3:0] tg, input logic [4:0] ln,
                           input logic [255:0] va, input logic [255:0] vx);
        int    le;
        int    nb;
        int    e;
        beat_t b;
        le = (int'(ln) > 16) ? 16 : int'(ln);
        if (sc) begin
            b = '0;
            b.a[15:0] = va[15:0];
            b.x[15:0] = vx[15:0];
            b.lv      = 4'b0001;
            b.last    = 1'b1;
            b.tag     = tg;
            exp_q.push_back(b);
        end else begin
            nb = (le == 0) ? 1 : (le + 3) / 4;
            for (int bi = 0; bi < nb; bi++) begin
                b      = '0;
                b.base = 4'(bi * 4);
                b.tag  = tg;
                b.last = (bi == nb - 1);
                for (int k = 0; k < 4; k++) begin
                    e = bi * 4 + k;
                    if (e < le) begin
                        b.lv[k]          = 1'b1;
                        b.a[k*16 +: 16]  = va[e*16 +: 16];
                        b.x[k*16 +: 16]  = vx[e*16 +: 16];
                    end
                end
                exp_q.push_back(b);
            end
        end
    endtask

    // One clock cycle: drive, sample mid-cycle against the model, advance.
    task automatic cyc(input logic iv, input logic ord, output logic acc);
        logic  ev;
        logic  er;
        beat_t eb;
        #1;
        in_valid  = iv;
        out_ready = ord;
        in_scalar = nxt_sc;
        in_tag    = nxt_tag;
        in_len    = nxt_len;
        in_vec_a  = nxt_a;
        in_vec_x  = nxt_x;
        #2;
        ev = (exp_q.size() != 0);
        er = !ev || (exp_q.size() == 1 && ord);
        eb = ev ? exp_q[0] : '0;
        obs_s = dut_beat();
        inr_s = in_ready;
        check("out_valid", 160'(out_valid), 160'(ev));
        check("in_ready", 160'(in_ready), 160'(er));
        check("beat", 160'(obs_s), 160'(eb));
        acc = iv && er;
        if (ev && ord) void'(exp_q.pop_front());
        if (acc) push_op(in_scalar, in_tag, in_len, in_vec_a, in_vec_x);
        @(posedge clk);
    endtask

    task automatic set_op(input logic sc, input logic [3:0] tg, input logic [4:0] ln);
        nxt_sc  = sc;
        nxt_tag = tg;
        nxt_len = ln;
        for (int i = 0; i < 8; i++) begin
            nxt_a[i*32 +: 32] = $urandom;
            nxt_x[i*32 +: 32] = $urandom;
        end
    endtask

    initial begin
        logic acc;
        logic pend;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_scalar = 1'b0;
        in_tag    = '0;
        in_len    = '0;
        in_vec_a  = '0;
        in_vec_x  = '0;
        set_op(1'b0, 4'h0, 5'd0);

        // Reset state.
        repeat (2) @(posedge clk);
        #3;
        check("rst_out_valid", 160'(out_valid), 160'(0));
        check("rst_in_ready", 160'(in_ready), 160'(0));
        check("rst_outputs", 160'(dut_beat()), 160'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);

        // len=16, element i = i*0x11.
        set_op(1'b0, 4'h5, 5'd16);
        for (int i = 0; i < 16; i++) nxt_a[i*16 +: 16] = 16'(i * 17);
        cyc(1'b1, 1'b1, acc);
        cyc(1'b0, 1'b1, acc);
        check("t1_beat0_a", 160'(obs_s.a), 160'(64'h0033_0022_0011_0000));
        check("t1_beat0_base", 160'(obs_s.base), 160'(0));
        cyc(1'b0, 1'b1, acc);
        cyc(1'b0, 1'b1, acc);
        cyc(1'b0, 1'b1, acc);
        check("t1_beat3_last", 160'(obs_s.last), 160'(1));
        check("t1_beat3_base", 160'(obs_s.base), 160'(12));
        check("t1_beat3_in_ready", 160'(inr_s), 160'(1));

        // len=6: two beats, partial mask on the second.
        set_op(1'b0, 4'h2, 5'd6);
        cyc(1'b1, 1'b1, acc);
        cyc(1'b0, 1'b1, acc);
        check("t2_lv0", 160'(obs_s.lv), 160'(4'b1111));
        cyc(1'b0, 1'b1, acc);
        check("t2_lv1", 160'(obs_s.lv), 160'(4'b0011));
        check("t2_a_hi", 160'(obs_s.a[63:32]), 160'(0));
        check("t2_last", 160'(obs_s.last), 160'(1));

        // Scalar op.
        set_op(1'b1, 4'h0, 5'd9);
        nxt_a[15:0] = 16'h1234;
        cyc(1'b1, 1'b1, acc);
        cyc(1'b0, 1'b1, acc);
        check("t3_lv", 160'(obs_s.lv), 160'(4'b0001));
        check("t3_a", 160'(obs_s.a), 160'(64'h1234));
        check("t3_last", 160'(obs_s.last), 160'(1));
        check("t3_tag", 160'(obs_s.tag), 160'(0));

        // len=8 with a 3-cycle stall at beat 1.
        set_op(1'b0, 4'h9, 5'd8);
        cyc(1'b1, 1'b1, acc);
        cyc(1'b0, 1'b1, acc);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, acc);
            check("t4_stall_base", 160'(obs_s.base), 160'(4));
            check("t4_stall_in_ready", 160'(inr_s), 160'(0));
        end
        cyc(1'b0, 1'b1, acc);
        check("t4_last", 160'(obs_s.last), 160'(1));

        // len=0 and len=20 (clamped).
        set_op(1'b0, 4'h3, 5'd0);
        cyc(1'b1, 1'b1, acc);
        cyc(1'b0, 1'b1, acc);
        check("t5_len0_lv", 160'(obs_s.lv), 160'(0));
        check("t5_len0_last", 160'(obs_s.last), 160'(1));
        set_op(1'b0, 4'h4, 5'd20);
        cyc(1'b1, 1'b1, acc);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, acc);
        check("t5_len20_lv", 160'(obs_s.lv), 160'(4'b1111));
        check("t5_len20_last", 160'(obs_s.last), 160'(1));

        // Reset during beat 2 of a 16-element op.
        set_op(1'b0, 4'h7, 5'd16);
        cyc(1'b1, 1'b1, acc);
        cyc(1'b0, 1'b1, acc);
        cyc(1'b0, 1'b1, acc);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_out_valid", 160'(out_valid), 160'(0));
        check("t6_rst_in_ready", 160'(in_ready), 160'(0));
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        set_op(1'b0, 4'h1, 5'd5);
        cyc(1'b1, 1'b1, acc);
        check("t6_accept_after_rst", 160'(inr_s), 160'(1));
        cyc(1'b0, 1'b1, acc);
        check("t6_base0", 160'(obs_s.base), 160'(0));
        cyc(1'b0, 1'b1, acc);

        // Random ops with random lane back-pressure.
        pend = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!pend && ($urandom % 3 != 0)) begin
                set_op(($urandom % 5) == 0, 4'($urandom), 5'($urandom_range(0, 31)));
                pend = 1'b1;
            end
            cyc(pend, ($urandom % 4) != 0, acc);
            if (acc) pend = 1'b0;
        end
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) cyc(1'b0, 1'b1, acc);
        check("drain", 160'(exp_q.size()), 160'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
